// File: rtl/timer_pkg.sv
// timer_pkg: register offsets, control/status bit positions and the control register type
package timer_pkg;
    localparam int MTIME_LO_OFF    = 'h00;
    localparam int MTIME_HI_OFF    = 'h04;
    localparam int MTIMECMP_LO_OFF = 'h08;
    localparam int MTIMECMP_HI_OFF = 'h0C;
    localparam int CTRL_OFF        = 'h10;
    localparam int STATUS_OFF      = 'h14;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_TIE     = 1;
    localparam int CTRL_EIE     = 2;
    localparam int CTRL_DIV_LSB = 8;
    localparam int CTRL_DIV_MSB = 15;

    localparam int STATUS_TPEND = 0;
    localparam int STATUS_EXT   = 1;

    typedef struct packed {
        logic [7:0] div;
        logic       eie;
        logic       tie;
        logic       en;
    } ctrl_t;
endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: two-flop synchronizer for an async level plus a gated rising-edge pulse
module irq_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en,
    input  logic irq,
    output logic level,
    output logic pulse
);
    logic s1, s2, s3;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            pulse <= 1'b0;
        end else begin
            s1    <= irq;
            s2    <= s1;
            s3    <= s2;
            pulse <= en & s2 & ~s3;
        end
    end

    assign level = s2;
endmodule

// File: rtl/timer_intr_ctrl.sv
// timer_intr_ctrl: memory-mapped mtime/mtimecmp timer with prescaler and external interrupt edge source
module timer_intr_ctrl
    import timer_pkg::*;
#(
    parameter int DW    = 32,
    parameter int ADDRW = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sel_i,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [ADDRW-1:0] addr_i,
    input  logic [DW-1:0]    wdata_i,
    output logic [DW-1:0]    rdata_o,
    input  logic             ext_irq_i,
    output logic             t_intr,
    output logic             e_intr
);
    ctrl_t           ctrl;
    logic [7:0]      pre_cnt;
    logic [DW-1:0]   mt_lo, mt_hi, cmp_lo, cmp_hi, shadow;
    logic [DW-1:0]   mt_lo_n, mt_hi_n, rd_mux;
    logic [ADDRW-1:0] wa;
    logic            wr, rd, tick, tpend, tpend_d, ext_lvl;
    logic            wr_lo, wr_hi, wr_clo, wr_chi, wr_ctrl;

    assign wa      = addr_i & ~ADDRW'(3);
    assign wr      = sel_i & we_i;
    assign rd      = sel_i & re_i;
    assign wr_lo   = wr && wa == ADDRW'(MTIME_LO_OFF);
    assign wr_hi   = wr && wa == ADDRW'(MTIME_HI_OFF);
    assign wr_clo  = wr && wa == ADDRW'(MTIMECMP_LO_OFF);
    assign wr_chi  = wr && wa == ADDRW'(MTIMECMP_HI_OFF);
    assign wr_ctrl = wr && wa == ADDRW'(CTRL_OFF);
    assign tick    = ctrl.en && pre_cnt == ctrl.div;

    // A bus write to either half wins over the tick and freezes the other half for that cycle
    always_comb begin
        mt_lo_n = wr_lo ? wdata_i : (tick && !wr_hi) ? mt_lo + DW'(1) : mt_lo;
        mt_hi_n = wr_hi ? wdata_i : (tick && !wr_lo && &mt_lo) ? mt_hi + DW'(1) : mt_hi;
    end

    always_comb begin
        rd_mux = wa == ADDRW'(MTIME_LO_OFF)    ? mt_lo  :
                 wa == ADDRW'(MTIME_HI_OFF)    ? shadow :
                 wa == ADDRW'(MTIMECMP_LO_OFF) ? cmp_lo :
                 wa == ADDRW'(MTIMECMP_HI_OFF) ? cmp_hi :
                 wa == ADDRW'(CTRL_OFF)        ? DW'({ctrl.div, 5'b0, ctrl.eie, ctrl.tie, ctrl.en}) :
                 wa == ADDRW'(STATUS_OFF)      ? DW'({ext_lvl, tpend}) : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl    <= '0;
            pre_cnt <= '0;
            mt_lo   <= '0;
            mt_hi   <= '0;
            cmp_lo  <= '1;
            cmp_hi  <= '1;
        end else begin
            pre_cnt <= (!ctrl.en || tick) ? 8'd0 : pre_cnt + 8'd1;
            mt_lo   <= mt_lo_n;
            mt_hi   <= mt_hi_n;
            if (wr_clo)
                cmp_lo <= wdata_i;
            if (wr_chi)
                cmp_hi <= wdata_i;
            if (wr_ctrl)
                ctrl <= '{div: wdata_i[CTRL_DIV_MSB:CTRL_DIV_LSB], eie: wdata_i[CTRL_EIE],
                          tie: wdata_i[CTRL_TIE], en: wdata_i[CTRL_EN]};
        end
    end

    // TPEND is the registered compare; the pulse fires only on its rising edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tpend   <= 1'b0;
            tpend_d <= 1'b0;
            t_intr  <= 1'b0;
        end else begin
            tpend   <= {mt_hi, mt_lo} >= {cmp_hi, cmp_lo};
            tpend_d <= tpend;
            t_intr  <= ctrl.tie & tpend & ~tpend_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_o <= '0;
            shadow  <= '0;
        end else if (rd) begin
            rdata_o <= rd_mux;
            if (wa == ADDRW'(MTIME_LO_OFF))
                shadow <= mt_hi;
        end
    end

    irq_sync_edge u_ext (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (ctrl.eie),
        .irq   (ext_irq_i),
        .level (ext_lvl),
        .pulse (e_intr)
    );
endmodule

// File: tb/tb_timer_intr_ctrl.sv
// tb_timer_intr_ctrl: directed bench with a read scoreboard for timer_intr_ctrl
module tb_timer_intr_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0, we = 1'b0, re = 1'b0, ext = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        t_intr, e_intr;
    int          total = 0, bad = 0;

    typedef struct {
        logic [31:0] v;
        string       tag;
    } exp_t;
    exp_t q[$];

    timer_intr_ctrl #(.DW(32), .ADDRW(5)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .sel_i     (sel),
        .we_i      (we),
        .re_i      (re),
        .addr_i    (addr),
        .wdata_i   (wdata),
        .rdata_o   (rdata),
        .ext_irq_i (ext),
        .t_intr    (t_intr),
        .e_intr    (e_intr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        cyc();
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
        exp_t e;
        sel = 1'b1; re = 1'b1; addr = a;
        q.push_back('{v: exp, tag: tag});
        cyc();
        sel = 1'b0; re = 1'b0;
        e = q.pop_front();
        chk(e.tag, rdata, e.v);
    endtask

    // Runs n cycles and reports how many cycles the selected pulse was high and the first one
    task automatic count_pulse(input bit use_ext, input int n, output int cnt, output int at);
        cnt = 0;
        at = -1;
        for (int i = 1; i <= n; i++) begin
            cyc();
            if (use_ext ? e_intr : t_intr) begin
                cnt++;
                if (at < 0) at = i;
            end
        end
    endtask

    initial begin
        int  cnt, at;
        bit  seen;
        // reset state
        #1;
        chk("rst_t_intr", {31'b0, t_intr}, 32'd0);
        chk("rst_e_intr", {31'b0, e_intr}, 32'd0);
        rd(5'h08, 32'h0, "rd_during_rst");
        cyc();
        rst = 1'b0;
        rd(5'h00, 32'h0, "rst_mtime_lo");
        rd(5'h04, 32'h0, "rst_mtime_hi");
        rd(5'h08, 32'hFFFF_FFFF, "rst_cmp_lo");
        rd(5'h0C, 32'hFFFF_FFFF, "rst_cmp_hi");
        rd(5'h10, 32'h0, "rst_ctrl");
        rd(5'h14, 32'h0, "rst_status");
        rd(5'h18, 32'h0, "unmapped_rd");
        // basic timer interrupt: mtime reaches 10 at edge 10, pulse after edge 12
        wr(5'h0C, 32'h0);
        wr(5'h08, 32'd10);
        wr(5'h18, 32'hDEAD_BEEF);
        wr(5'h10, 32'h0000_0003);
        count_pulse(1'b0, 20, cnt, at);
        chk("t_pulse_count", cnt, 1);
        chk("t_pulse_cycle", at, 12);
        wr(5'h10, 32'h0000_0002);
        rd(5'h00, 32'd21, "mtime_stopped");
        rd(5'h14, 32'h1, "tpend_held");
        rd(5'h18, 32'h0, "unmapped_wr_ignored");
        // prescaler DIV=3: one tick per 4 cycles, then freeze
        wr(5'h00, 32'h0);
        wr(5'h10, 32'h0000_0301);
        for (int i = 0; i < 15; i++) cyc();
        wr(5'h10, 32'h0000_0300);
        rd(5'h00, 32'd4, "prescale_mtime");
        rd(5'h10, 32'h0000_0300, "ctrl_readback");
        for (int i = 0; i < 10; i++) cyc();
        rd(5'h00, 32'd4, "frozen_mtime");
        // carry from low word into high word
        wr(5'h00, 32'hFFFF_FFFF);
        wr(5'h04, 32'd5);
        wr(5'h10, 32'h1);
        wr(5'h10, 32'h0);
        rd(5'h00, 32'h0, "carry_lo");
        rd(5'h04, 32'd6, "carry_hi");
        // shadowed HI survives a carry between the two reads
        wr(5'h00, 32'hFFFF_FFFE);
        wr(5'h04, 32'd7);
        wr(5'h10, 32'h1);
        rd(5'h00, 32'hFFFF_FFFE, "coh_lo");
        rd(5'h04, 32'd7, "coh_hi_shadow");
        wr(5'h10, 32'h0);
        rd(5'h00, 32'd1, "coh_lo2");
        rd(5'h04, 32'd8, "coh_hi2");
        // re-arm after raising mtimecmp
        wr(5'h00, 32'h0);
        wr(5'h04, 32'h0);
        wr(5'h08, 32'd20);
        wr(5'h10, 32'h3);
        count_pulse(1'b0, 25, cnt, at);
        chk("rearm_first_cycle", at, 22);
        chk("rearm_first_count", cnt, 1);
        wr(5'h08, 32'd40);
        count_pulse(1'b0, 20, cnt, at);
        chk("rearm_second_cycle", at, 16);
        chk("rearm_second_count", cnt, 1);
        // bus write beats a coincident tick
        wr(5'h10, 32'h0);
        wr(5'h00, 32'hFFFF_FFFF);
        wr(5'h04, 32'd3);
        wr(5'h10, 32'h1);
        wr(5'h04, 32'd9);
        rd(5'h00, 32'hFFFF_FFFF, "hi_wr_lo_held");
        wr(5'h10, 32'h0);
        rd(5'h04, 32'd9, "hi_wr_shadow");
        rd(5'h00, 32'd1, "after_hi_wr_lo");
        rd(5'h04, 32'd10, "after_hi_wr_hi");
        wr(5'h10, 32'h1);
        wr(5'h00, 32'h1234_0000);
        rd(5'h00, 32'h1234_0000, "lo_wr_wins");
        wr(5'h10, 32'h0);
        // external interrupt path
        wr(5'h10, 32'h4);
        ext = 1'b1;
        count_pulse(1'b1, 6, cnt, at);
        chk("ext_cycle", at, 3);
        chk("ext_count", cnt, 1);
        rd(5'h14, 32'h3, "status_ext");
        ext = 1'b0;
        count_pulse(1'b1, 5, cnt, at);
        chk("ext_fall_none", cnt, 0);
        ext = 1'b1;
        count_pulse(1'b1, 6, cnt, at);
        chk("ext_second_count", cnt, 1);
        ext = 1'b0;
        wr(5'h10, 32'h0);
        for (int i = 0; i < 4; i++) cyc();
        ext = 1'b1;
        count_pulse(1'b1, 6, cnt, at);
        chk("ext_disabled", cnt, 0);
        ext = 1'b0;
        // async reset while t_intr is high
        wr(5'h00, 32'h0);
        wr(5'h04, 32'h0);
        wr(5'h08, 32'd5);
        wr(5'h0C, 32'h0);
        wr(5'h10, 32'h3);
        rd(5'h10, 32'h3, "pre_rst_ctrl");
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc();
            seen = t_intr;
        end
        chk("pre_rst_pulse_seen", {31'b0, seen}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_t_intr", {31'b0, t_intr}, 32'd0);
        chk("async_rst_rdata", rdata, 32'h0);
        chk("async_rst_e_intr", {31'b0, e_intr}, 32'd0);
        cyc();
        rst = 1'b0;
        rd(5'h08, 32'hFFFF_FFFF, "post_rst_cmp_lo");
        rd(5'h10, 32'h0, "post_rst_ctrl");
        rd(5'h00, 32'h0, "post_rst_mtime");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
